// File: rtl/ex_alu_stage_pkg.sv
// Shared definitions for the execute ALU stage. The operation codes mirror the
// ALU_* encodings of riscv_define.vh, so the decoder and this stage agree.
package ex_alu_stage_pkg;

  localparam int ALU_CTRL_W = 4;
  localparam int SHAMT_W    = 5;

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLL  = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRL  = 4'b0011;
  localparam logic [ALU_CTRL_W-1:0] ALU_SRA  = 4'b0100;
  localparam logic [ALU_CTRL_W-1:0] ALU_SSUB = 4'b0101;
  localparam logic [ALU_CTRL_W-1:0] ALU_USUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_XOR  = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR   = 4'b1000;
  localparam logic [ALU_CTRL_W-1:0] ALU_AND  = 4'b1001;

endpackage

// File: rtl/ex_alu_stage_alu_core.sv
// Purely combinational ALU: result plus compare flags for every operation code.
// Unknown codes fall back to ADD so a decoder glitch never produces X data.
module alu_core
  import ex_alu_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [ALU_CTRL_W-1:0] i_alu_control,
  input  logic [XLEN-1:0]       a,
  input  logic [XLEN-1:0]       b,
  output logic [XLEN-1:0]       result,
  output logic                  zero,
  output logic                  lt,
  output logic                  ltu
);

  logic [SHAMT_W-1:0] shamt_s;
  logic               lt_s;
  logic               ltu_s;

  assign shamt_s = b[SHAMT_W-1:0];
  assign lt_s    = ($signed(a) < $signed(b));
  assign ltu_s   = (a < b);

  assign zero = (a == b);
  assign lt   = lt_s;
  assign ltu  = ltu_s;

  // Result selection by operation code
  always_comb begin
    result = {XLEN{1'b0}};
    case (i_alu_control)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLL:  result = a << shamt_s;
      ALU_SRL:  result = a >> shamt_s;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt_s);
      ALU_SSUB: result = {{(XLEN-1){1'b0}}, lt_s};
      ALU_USUB: result = {{(XLEN-1){1'b0}}, ltu_s};
      ALU_XOR:  result = a ^ b;
      ALU_OR:   result = a | b;
      ALU_AND:  result = a & b;
      default:  result = a + b;
    endcase
  end

endmodule

// File: rtl/ex_alu_stage.sv
// Registered execute stage: ALU result and flags held in a two-entry skid
// buffer (main drives the outputs, skid absorbs one entry under back-pressure).
module ex_alu_stage
  import ex_alu_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RD_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [ALU_CTRL_W-1:0] i_alu_control,
  input  logic [XLEN-1:0]       i_op_a,
  input  logic [XLEN-1:0]       i_op_b,
  input  logic [RD_W-1:0]       i_rd,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [XLEN-1:0]       o_result,
  output logic                  o_zero,
  output logic                  o_lt,
  output logic                  o_ltu,
  output logic [RD_W-1:0]       o_rd
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic            zero;
    logic            lt;
    logic            ltu;
    logic [RD_W-1:0] rd;
  } entry_t;

  entry_t new_s;
  entry_t main_r;
  entry_t skid_r;
  entry_t main_nxt_s;
  entry_t skid_nxt_s;
  logic   main_valid_r;
  logic   skid_valid_r;
  logic   ready_r;
  logic   main_valid_nxt_s;
  logic   skid_valid_nxt_s;
  logic   accept_s;
  logic   xfer_s;

  alu_core #(
    .XLEN (XLEN)
  ) u_alu_core (
    .i_alu_control (i_alu_control),
    .a             (i_op_a),
    .b             (i_op_b),
    .result        (new_s.result),
    .zero          (new_s.zero),
    .lt            (new_s.lt),
    .ltu           (new_s.ltu)
  );

  assign new_s.rd = i_rd;
  assign accept_s = i_valid & ready_r;
  assign xfer_s   = main_valid_r & i_ready;

  // Next-state of the buffer; flush wins over accept and transfer
  always_comb begin
    main_nxt_s       = main_r;
    skid_nxt_s       = skid_r;
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    if (i_flush) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (accept_s) begin
      if (!main_valid_r || xfer_s) begin
        // Oldest held entry always advances to main first to keep order.
        if (skid_valid_r) begin
          main_nxt_s       = skid_r;
          skid_nxt_s       = new_s;
          main_valid_nxt_s = 1'b1;
          skid_valid_nxt_s = 1'b1;
        end else begin
          main_nxt_s       = new_s;
          main_valid_nxt_s = 1'b1;
          skid_valid_nxt_s = 1'b0;
        end
      end else begin
        skid_nxt_s       = new_s;
        skid_valid_nxt_s = 1'b1;
      end
    end else if (xfer_s) begin
      if (skid_valid_r) begin
        main_nxt_s       = skid_r;
        main_valid_nxt_s = 1'b1;
        skid_valid_nxt_s = 1'b0;
      end else begin
        main_valid_nxt_s = 1'b0;
      end
    end else begin
      main_valid_nxt_s = main_valid_r;
      skid_valid_nxt_s = skid_valid_r;
    end
  end

  // Buffer state and the registered ready flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_r       <= '0;
      skid_r       <= '0;
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      ready_r      <= 1'b1;
    end else begin
      main_r       <= main_nxt_s;
      skid_r       <= skid_nxt_s;
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      ready_r      <= ~skid_valid_nxt_s;
    end
  end

  assign o_ready  = ready_r;
  assign o_valid  = main_valid_r;
  assign o_result = main_r.result;
  assign o_zero   = main_r.zero;
  assign o_lt     = main_r.lt;
  assign o_ltu    = main_r.ltu;
  assign o_rd     = main_r.rd;

endmodule

// File: doc/ex_alu_stage.md
# ex_alu_stage

Registered execute stage sitting directly downstream of the ALU-control decoder: it consumes the 4-bit ALU operation code together with the two operands and destination register, computes the result and compare flags, and hands them to the memory stage over a valid/ready handshake. A two-entry skid buffer decouples the stage from downstream back-pressure while keeping full throughput, and a flush input discards in-flight work on branch/jump redirect.

## Interface
Parameters:
- XLEN, 32, operand/result width
- RD_W, 5, destination-register index width

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_flush  in  1  discard all held and incoming work this cycle
- i_valid  in  1  upstream entry valid
- o_ready  out  1  stage can accept an entry this cycle
- i_alu_control  in  4  ALU operation code (`ALU_*` from riscv_define.vh)
- i_op_a  in  XLEN  operand A (rs1 or PC)
- i_op_b  in  XLEN  operand B (rs2 or immediate)
- i_rd  in  RD_W  destination register index
- o_valid  out  1  output entry valid
- i_ready  in  1  downstream accepts output this cycle
- o_result  out  XLEN  ALU result
- o_zero  out  1  op_a == op_b
- o_lt  out  1  signed op_a < op_b
- o_ltu  out  1  unsigned op_a < op_b
- o_rd  out  RD_W  destination register index

## Operation
- Accept = i_valid & o_ready; transfer out = o_valid & i_ready.
- Result per code: ADD a+b; SUB a-b; SLL a << b[4:0]; SRL logical a >> b[4:0]; SRA arithmetic a >>> b[4:0]; XOR/OR/AND bitwise; SSUB {0…, signed a<b}; USUB {0…, unsigned a<b}; any other code -> ADD. Arithmetic wraps modulo 2^XLEN; no overflow flag.
- Flags o_zero/o_lt/o_ltu computed from the same operands for every code and captured with the result.
- Storage: main register (drives outputs) and skid register. o_ready = ~skid_valid, registered.
- On accept: if main empty or transferring out this cycle, computed entry goes to main (skid, if valid, moves to main first and new entry goes to skid); otherwise entry goes to skid.
- On transfer out with skid valid and no accept: skid moves to main, skid empties.
- Order strictly preserved; no entry dropped or duplicated except by flush/reset.
- i_flush: next edge clears main_valid and skid_valid; any accept in the flush cycle is discarded. Flush dominates accept and transfer.

## Timing
- Latency 1 cycle: entry accepted at edge N is visible on outputs after edge N when main was empty.
- Throughput 1 entry/cycle with i_ready held high.
- Downstream stall: first stalled cycle absorbs one entry in skid; o_ready falls the cycle after skid fills and rises the cycle after skid drains.
- Reset (sync, mid-operation included): o_valid=0, o_ready=1, o_result=0, o_zero=0, o_lt=0, o_ltu=0, o_rd=0; held entries lost.
- Data outputs are don't-care-stable while o_valid=0 (hold last value); must not change while o_valid=1 and i_ready=0.

## Structure
- `ALU_*` codes stay in shared riscv_define.vh; no new codes defined here.
- Sub-module alu_core: purely combinational (i_alu_control, a, b) -> (result, zero, lt, ltu); instantiated once ahead of the buffer.
- ex_alu_stage holds only the two-entry skid buffer and handshake logic.

## Test plan
- Each code with a=0xFFFF_FFF0, b=0x0000_0004, i_ready=1 -> ADD 0xFFFF_FFF4, SUB 0xFFFF_FFEC, SLL 0xFFFF_FF00, SRL 0x0FFF_FFFF, SRA 0xFFFF_FFFF, SSUB 1, USUB 0, XOR 0xFFFF_FFF4, OR 0xFFFF_FFF4, AND 0; o_lt=1, o_ltu=0, one cycle after accept.
- Back-to-back 8 entries, i_ready=1 -> 8 outputs on consecutive cycles, in order, o_ready constantly 1.
- i_ready=0 for 3 cycles while i_valid=1 -> main and skid fill, o_ready=0 from second stall cycle; on release outputs drain in order, nothing lost.
- i_flush while both entries valid and i_valid=1 -> next cycle o_valid=0, o_ready=1; flushed entries never appear.
- i_rst asserted mid-stream -> next cycle all outputs at reset values; first entry after release appears 1 cycle after accept.
- Undefined code 4'b1111, a=3, b=5 -> o_result=8, o_zero=0, o_lt=1.
